// File: rtl/mul8s_dot_acc.sv
// rtl/mul8s_dot_acc.sv - frame-delimited dot-product accumulator for mul8s_* products
// Sums 16-bit signed products per frame; emits sum, term count and overflow flag.
module mul8s_dot_acc #(
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 16,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_sat
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [ACC_W:0]   sum;
    logic             sum_ovf;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept;

    // A pending result blocks new beats unless it drains this same cycle.
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        sum     = {acc[ACC_W-1], acc} + {{(ACC_W-15){in_prod[15]}}, in_prod};
        sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
        acc_nxt = sum[ACC_W-1:0];
        if (SAT_EN && sum_ovf) begin
            acc_nxt = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        cnt_nxt = (&cnt) ? cnt : cnt + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_acc   <= '0;
            out_cnt   <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept && in_last) begin
                out_acc   <= acc_nxt;
                out_cnt   <= cnt_nxt;
                out_sat   <= ovf | sum_ovf;
                out_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
                ovf       <= 1'b0;
            end else begin
                if (accept) begin
                    acc <= acc_nxt;
                    cnt <= cnt_nxt;
                    ovf <= ovf | sum_ovf;
                end
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
